// File: rtl/sipo_frame_ctrl.sv
// Serial-to-parallel framing controller: detects frame start, drives the
// external SIPO shift enable, counts data bits, optionally checks a trailing
// parity bit and publishes each finished word through a valid/ready register.
//
//   state | meaning
//   ------+--------------------------------------------------------------
//   IDLE  | waiting for frame_start; holding register may still be full
//   DATA  | sampling data bits 2..WIDTH, one per cycle
//   PAR   | sampling the parity bit (only reached when PARITY_EN = 1)
module sipo_frame_ctrl #(
    parameter int WIDTH      = 4,
    parameter bit PARITY_EN  = 1'b1,
    parameter bit ODD_PARITY = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             serial_in,
    input  logic             frame_start,
    input  logic             out_ready,
    output logic             shift_en,
    output logic [WIDTH-1:0] data_out,
    output logic             data_valid,
    output logic             parity_err,
    output logic             overrun,
    output logic             busy
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DATA = 2'd1,
        PAR  = 2'd2
    } state_t;

    state_t           state, state_nxt;
    logic [CW-1:0]    count, count_nxt;
    logic [WIDTH-1:0] sreg, sreg_nxt, sreg_shifted;
    logic [WIDTH-1:0] word;
    logic             par_bit;
    logic             complete;
    logic             shift_raw;
    logic             perr_new;
    logic             load;

    assign sreg_shifted = {sreg[WIDTH-2:0], serial_in};

    // Next-state, bit counting and completion detection.
    // A frame_start in any state restarts the frame with this cycle's bit.
    always_comb begin
        state_nxt = state;
        count_nxt = count;
        sreg_nxt  = sreg;
        shift_raw = 1'b0;
        complete  = 1'b0;
        word      = sreg;
        par_bit   = 1'b0;
        case (state)
            IDLE: begin
                if (frame_start) begin
                    shift_raw = 1'b1;
                    sreg_nxt  = sreg_shifted;
                    count_nxt = CW'(1);
                    state_nxt = DATA;
                end
            end
            DATA: begin
                shift_raw = 1'b1;
                sreg_nxt  = sreg_shifted;
                if (frame_start) begin
                    count_nxt = CW'(1);
                end else if (count == CW'(WIDTH - 1)) begin
                    if (PARITY_EN) begin
                        count_nxt = CW'(WIDTH);
                        state_nxt = PAR;
                    end else begin
                        complete  = 1'b1;
                        word      = sreg_shifted;
                        count_nxt = '0;
                        state_nxt = IDLE;
                    end
                end else begin
                    count_nxt = count + 1'b1;
                end
            end
            PAR: begin
                if (frame_start) begin
                    shift_raw = 1'b1;
                    sreg_nxt  = sreg_shifted;
                    count_nxt = CW'(1);
                    state_nxt = DATA;
                end else begin
                    complete  = 1'b1;
                    par_bit   = serial_in;
                    count_nxt = '0;
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
                count_nxt = '0;
            end
        endcase
    end

    // Parity error is (data XOR parity) differing from the configured sense.
    assign perr_new = PARITY_EN ? ((^word ^ par_bit) != ODD_PARITY) : 1'b0;

    // A new word loads when the holding register is empty or drains this cycle.
    assign load = complete && (!data_valid || out_ready);

    // Reset overrides everything, including the combinational shift enable.
    assign shift_en = shift_raw && !reset;
    assign busy     = (state != IDLE);

    // State, counter and shift register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            count <= '0;
            sreg  <= '0;
        end else begin
            state <= state_nxt;
            count <= count_nxt;
            sreg  <= sreg_nxt;
        end
    end

    // Holding register with valid/ready handshake and sticky overrun.
    always_ff @(posedge clk) begin
        if (reset) begin
            data_out   <= '0;
            data_valid <= 1'b0;
            parity_err <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            if (load) begin
                data_out   <= word;
                parity_err <= perr_new;
                data_valid <= 1'b1;
            end else if (data_valid && out_ready) begin
                data_valid <= 1'b0;
            end
            if (complete && !load) begin
                overrun <= 1'b1;
            end
        end
    end

endmodule
